// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared types and constants for the two-port SDRAM burst arbiter.
//   state_t    : controller state (IDLE, STROBE, WAIT, DONE)
//   ADDR_W     : memory address width
//   DATA_W     : memory data width
//   LEN_W      : burst length field width (length minus one)
//   WAIT_W     : width of the memory-latency counter (covers MEM_LAT up to 15)
//   beat_addr  : base address plus beat index, wrapping modulo 2^ADDR_W
package sdram_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 3;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Address of a given beat; the addition simply drops the carry so that
    // 0xFFFF is followed by 0x0000.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  idx
    );
        return base + ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_arb2.sv
// rr_arb2
// Two-port round-robin grant selection (purely combinational).
// Ports:
//   req   : request levels, bit 0 = m0, bit 1 = m1
//   prio  : port that wins when both request (0 = m0, 1 = m1)
//   valid : at least one port is requesting
//   sel   : selected port index (meaningful only when valid = 1)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = req[0] | req[1];
        sel   = 1'b0;
        if (req[0] && req[1]) begin
            sel = prio;
        end else begin
            sel = req[1];
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Arbitrates two byte-burst requesters onto a single SDRAM-style port with a
// fixed read latency of MEM_LAT cycles. Each beat is one STROBE cycle followed
// by MEM_LAT WAIT cycles; a DONE cycle closes the burst.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   mX_req                    : requester X wants a burst (level)
//   mX_addr / mX_len          : burst base address / length minus one
//   mX_wr_rd                  : 1 = write, 0 = read
//   mX_wdata                  : current write byte from requester X
//   mX_gnt / mX_beat / mX_done: one-cycle pulses to requester X
//   mX_rdata                  : read byte, valid with mX_beat on reads
//   sdram_addr / sdram_dout   : memory address / write data
//   sdram_din                 : memory read data
//   sdram_wr_rd / sdram_mstrb : memory direction / per-byte strobe
//   busy                      : controller is not IDLE
// Every output is driven straight from a flop.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [LEN_W-1:0]  m0_len,
    input  logic              m0_wr_rd,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_beat,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [LEN_W-1:0]  m1_len,
    input  logic              m1_wr_rd,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_beat,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,

    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dout,
    input  logic [DATA_W-1:0] sdram_din,
    output logic              sdram_wr_rd,
    output logic              sdram_mstrb,
    output logic              busy
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);

    state_t            state;
    state_t            next_state;

    logic              owner;
    logic              prio;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  beat_idx;
    logic [WAIT_W-1:0] wait_cnt;

    logic              arb_valid;
    logic              arb_sel;
    logic              start;
    logic              wait_end;
    logic              last_beat;
    logic              sel_port;
    logic [DATA_W-1:0] sel_wdata;

    logic [1:0]        gnt_q, beat_q, done_q;
    logic [1:0]        gnt_d, beat_d, done_d;
    logic              busy_d, mstrb_d, wr_rd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dout_d, rdata0_d, rdata1_d;

    rr_arb2 u_rr_arb2 (
        .req   ({m1_req, m0_req}),
        .prio  (prio),
        .valid (arb_valid),
        .sel   (arb_sel)
    );

    assign start     = (state == IDLE) && arb_valid;
    assign wait_end  = (state == WAIT) && (wait_cnt == WAIT_LAST);
    assign last_beat = (beat_idx == len_q);

    // The port whose wdata feeds the next strobe: the newly granted port on
    // the grant edge, the latched owner for every later beat.
    assign sel_port  = start ? arb_sel : owner;
    assign sel_wdata = sel_port ? m1_wdata : m0_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arb_valid) next_state = STROBE;
            STROBE:  next_state = WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) next_state = last_beat ? DONE : STROBE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: computes the value every output register takes on the
    // coming edge, so all visible outputs stay registered.
    always_comb begin
        gnt_d    = 2'b00;
        beat_d   = 2'b00;
        done_d   = 2'b00;
        busy_d   = (next_state != IDLE);
        mstrb_d  = (next_state == STROBE);
        addr_d   = sdram_addr;
        dout_d   = sdram_dout;
        wr_rd_d  = sdram_wr_rd;
        rdata0_d = m0_rdata;
        rdata1_d = m1_rdata;

        if (start) begin
            gnt_d[arb_sel] = 1'b1;
            wr_rd_d        = arb_sel ? m1_wr_rd : m0_wr_rd;
            addr_d         = arb_sel ? m1_addr : m0_addr;
        end else if (next_state == STROBE) begin
            addr_d = beat_addr(base_q, beat_idx + LEN_W'(1));
        end

        // Write beats are reported in the strobe cycle itself, giving the
        // requester the whole WAIT window to present the next byte.
        if (next_state == STROBE) begin
            dout_d = sel_wdata;
            if (wr_rd_d) begin
                beat_d[sel_port] = 1'b1;
            end
        end

        // Read data is only trusted on the last WAIT cycle of each beat.
        if (wait_end && !sdram_wr_rd) begin
            beat_d[owner] = 1'b1;
            if (owner) begin
                rdata1_d = sdram_din;
            end else begin
                rdata0_d = sdram_din;
            end
        end

        if (wait_end && last_beat) begin
            done_d[owner] = 1'b1;
        end
    end

    // Burst context: owner, length, base, beat and latency counters, and the
    // tie-break pointer, which always favours the port not served last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner    <= 1'b0;
            prio     <= 1'b0;
            len_q    <= '0;
            base_q   <= '0;
            beat_idx <= '0;
            wait_cnt <= '0;
        end else begin
            if (start) begin
                owner    <= arb_sel;
                prio     <= ~arb_sel;
                len_q    <= arb_sel ? m1_len : m0_len;
                base_q   <= arb_sel ? m1_addr : m0_addr;
                beat_idx <= '0;
            end else if (wait_end && !last_beat) begin
                beat_idx <= beat_idx + LEN_W'(1);
            end

            if (state == STROBE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q       <= 2'b00;
            beat_q      <= 2'b00;
            done_q      <= 2'b00;
            busy        <= 1'b0;
            sdram_mstrb <= 1'b0;
            sdram_addr  <= '0;
            sdram_dout  <= '0;
            sdram_wr_rd <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            gnt_q       <= gnt_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            busy        <= busy_d;
            sdram_mstrb <= mstrb_d;
            sdram_addr  <= addr_d;
            sdram_dout  <= dout_d;
            sdram_wr_rd <= wr_rd_d;
            m0_rdata    <= rdata0_d;
            m1_rdata    <= rdata1_d;
        end
    end

    assign m0_gnt  = gnt_q[0];
    assign m1_gnt  = gnt_q[1];
    assign m0_beat = beat_q[0];
    assign m1_beat = beat_q[1];
    assign m0_done = done_q[0];
    assign m1_done = done_q[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Self-checking bench for sdram_arbiter (MEM_LAT = 2). A burst-level model
// predicts every cycle's outputs from the arbitration and timing rules; a
// table of single bursts, hand-written contention and reset sequences and a
// randomized phase are all checked against it.
module tb_sdram_arbiter;

    localparam int MEM_LAT = 2;
    localparam int P       = MEM_LAT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [2:0]  m0_len = '0, m1_len = '0;
    logic        m0_wr_rd = 1'b0, m1_wr_rd = 1'b0;
    logic [7:0]  m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_beat, m1_beat, m0_done, m1_done;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [15:0] sdram_addr;
    logic [7:0]  sdram_dout;
    logic [7:0]  sdram_din = '0;
    logic        sdram_wr_rd, sdram_mstrb, busy;

    always #5 clk = ~clk;

    sdram_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len), .m0_wr_rd(m0_wr_rd),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_beat(m0_beat), .m0_rdata(m0_rdata),
        .m0_done(m0_done),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_len(m1_len), .m1_wr_rd(m1_wr_rd),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_beat(m1_beat), .m1_rdata(m1_rdata),
        .m1_done(m1_done),
        .sdram_addr(sdram_addr), .sdram_dout(sdram_dout), .sdram_din(sdram_din),
        .sdram_wr_rd(sdram_wr_rd), .sdram_mstrb(sdram_mstrb), .busy(busy)
    );

    typedef struct {
        bit          rst;
        bit          req0, req1;
        logic [15:0] addr0, addr1;
        logic [2:0]  len0, len1;
        bit          wr0, wr1;
        logic [7:0]  wd0, wd1;
    } stim_t;

    // ctrl = {m1_gnt, m0_gnt, m1_beat, m0_beat, m1_done, m0_done, busy, mstrb}
    typedef struct {
        logic [7:0]  ctrl;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        wr_rd;
        logic [7:0]  rd0, rd1;
        bit          c_addr, c_dout, c_wr, c_rd0, c_rd1;
    } exp_t;

    typedef struct {
        bit          port;
        logic [15:0] addr;
        logic [2:0]  len;
        bit          wr;
        logic [7:0]  wbase;
        int          exp_strobes;
        int          exp_done;
        logic [15:0] exp_last_addr;
        logic [7:0]  exp_last_data;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    exp_t        expc;
    bit          exp_valid = 0;

    // Burst-level reference state
    bit          b_act = 0;
    int          b_start, b_end, b_len;
    bit          b_own, b_wr;
    logic [15:0] b_base;
    bit          last_srv = 1'b1;

    // Memory model: one history slot per cycle of observed strobes
    bit          hist_v [16];
    logic [15:0] hist_a [16];

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Compare this cycle's outputs with the prediction, then play memory.
    task automatic observe();
        @(negedge clk);
        cyc++;
        if (exp_valid) begin
            check_output("ctrl", {m1_gnt, m0_gnt, m1_beat, m0_beat, m1_done, m0_done, busy, sdram_mstrb},
                         expc.ctrl);
            if (expc.c_addr) check_output("sdram_addr", sdram_addr, expc.addr);
            if (expc.c_dout) check_output("sdram_dout", sdram_dout, expc.dout);
            if (expc.c_wr)   check_output("sdram_wr_rd", sdram_wr_rd, expc.wr_rd);
            if (expc.c_rd0)  check_output("m0_rdata", m0_rdata, expc.rd0);
            if (expc.c_rd1)  check_output("m1_rdata", m1_rdata, expc.rd1);
        end
        for (int i = 15; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_a[i] = hist_a[i-1];
        end
        hist_v[0] = (sdram_mstrb === 1'b1);
        hist_a[0] = sdram_addr;
        sdram_din = hist_v[MEM_LAT] ? mem_f(hist_a[MEM_LAT]) : 8'($urandom);
    endtask

    // Drive this cycle's inputs and predict the next cycle's outputs.
    task automatic apply_stimulus(input stim_t s);
        int n, t;
        rst = s.rst;
        m0_req = s.req0;   m1_req = s.req1;
        m0_addr = s.addr0; m1_addr = s.addr1;
        m0_len = s.len0;   m1_len = s.len1;
        m0_wr_rd = s.wr0;  m1_wr_rd = s.wr1;
        m0_wdata = s.wd0;  m1_wdata = s.wd1;

        expc = '{default: 0};
        exp_valid = 1;
        if (!s.rst) begin
            b_act = 0;
            last_srv = 1'b1;
            expc.c_addr = 1; expc.c_dout = 1; expc.c_wr = 1; expc.c_rd0 = 1; expc.c_rd1 = 1;
        end else begin
            if ((!b_act || cyc > b_end) && (s.req0 || s.req1)) begin
                b_own    = (s.req0 && s.req1) ? !last_srv : s.req1;
                last_srv = b_own;
                b_act    = 1;
                b_start  = cyc + 1;
                b_base   = b_own ? s.addr1 : s.addr0;
                b_len    = int'(b_own ? s.len1 : s.len0);
                b_wr     = b_own ? s.wr1 : s.wr0;
                b_end    = b_start + (b_len + 1) * P;
            end
            n = cyc + 1;
            if (b_act && n >= b_start && n <= b_end) begin
                t = n - b_start;
                expc.ctrl[1] = 1'b1;
                expc.wr_rd = b_wr;
                expc.c_wr = 1;
                if (t == 0) expc.ctrl[6 + b_own] = 1'b1;
                if (t % P == 0 && t < (b_len + 1) * P) begin
                    expc.ctrl[0] = 1'b1;
                    expc.addr = b_base + 16'(t / P);
                    expc.c_addr = 1;
                    if (b_wr) begin
                        expc.dout = b_own ? s.wd1 : s.wd0;
                        expc.c_dout = 1;
                        expc.ctrl[4 + b_own] = 1'b1;
                    end
                end
                if (!b_wr && t > 0 && t % P == 0) begin
                    expc.ctrl[4 + b_own] = 1'b1;
                    if (b_own) begin
                        expc.rd1 = mem_f(b_base + 16'(t / P - 1));
                        expc.c_rd1 = 1;
                    end else begin
                        expc.rd0 = mem_f(b_base + 16'(t / P - 1));
                        expc.c_rd0 = 1;
                    end
                end
                if (n == b_end) expc.ctrl[2 + b_own] = 1'b1;
            end
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            observe();
            apply_stimulus(idle_stim());
        end
    endtask

    // One isolated burst; the requester drops req right after its grant.
    task automatic run_vector(input vec_t v, input int idx);
        stim_t       s;
        int          done_at, strobes;
        logic [15:0] last_a;
        logic [7:0]  last_d, wd;
        s = idle_stim();
        wd = v.wbase;
        done_at = -1; strobes = 0; last_a = 'x; last_d = 'x;
        if (v.port) begin
            s.req1 = 1; s.addr1 = v.addr; s.len1 = v.len; s.wr1 = v.wr;
        end else begin
            s.req0 = 1; s.addr0 = v.addr; s.len0 = v.len; s.wr0 = v.wr;
        end
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            observe();
            if (i > 0) begin
                if (v.port ? m1_gnt : m0_gnt) begin
                    s.req0 = 0; s.req1 = 0;
                end
                if (sdram_mstrb) begin
                    strobes++;
                    last_a = sdram_addr;
                    if (v.wr) last_d = sdram_dout;
                end
                if (v.port ? m1_beat : m0_beat) begin
                    if (v.wr) wd = wd + 8'h11;
                    else last_d = v.port ? m1_rdata : m0_rdata;
                end
                if (v.port ? m1_done : m0_done) done_at = i;
            end
            s.wd0 = wd; s.wd1 = wd;
            apply_stimulus(s);
        end
        check_output($sformatf("vec%0d_done_cycle", idx), done_at, v.exp_done);
        check_output($sformatf("vec%0d_strobes", idx), strobes, v.exp_strobes);
        check_output($sformatf("vec%0d_last_addr", idx), last_a, v.exp_last_addr);
        check_output($sformatf("vec%0d_last_data", idx), last_d, v.exp_last_data);
        idle_cycles(3);
    endtask

    initial begin
        vec_t  vecs [6];
        stim_t s;
        int    g_port [3];
        int    g_cyc  [3];
        int    ng, ndone;

        vecs[0] = '{1'b0, 16'h1234, 3'd0, 1'b0, 8'h00, 1, 4,  16'h1234, 8'hA5};
        vecs[1] = '{1'b1, 16'h0100, 3'd3, 1'b1, 8'h11, 4, 13, 16'h0103, 8'h44};
        vecs[2] = '{1'b0, 16'hFFFE, 3'd3, 1'b0, 8'h00, 4, 13, 16'h0001, 8'h82};
        vecs[3] = '{1'b1, 16'h8000, 3'd7, 1'b0, 8'h00, 8, 25, 16'h8007, 8'h04};
        vecs[4] = '{1'b0, 16'hFFFF, 3'd1, 1'b1, 8'h5A, 2, 7,  16'h0000, 8'h6B};
        vecs[5] = '{1'b1, 16'h00FF, 3'd0, 1'b1, 8'hC3, 1, 4,  16'h00FF, 8'hC3};

        s = idle_stim();
        s.rst = 0;
        for (int i = 0; i < 3; i++) begin
            observe();
            apply_stimulus(s);
        end
        idle_cycles(2);

        for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

        // Contention from reset: m0, then m1 one cycle after m0's IDLE, then m0.
        s = idle_stim();
        s.rst = 0;
        for (int i = 0; i < 2; i++) begin
            observe();
            apply_stimulus(s);
        end
        s = idle_stim();
        s.req0 = 1; s.req1 = 1; s.addr0 = 16'h0A00; s.addr1 = 16'h0B00;
        for (int i = 0; i < 3; i++) begin
            g_port[i] = -1;
            g_cyc[i]  = -1;
        end
        ng = 0;
        for (int j = 0; j < 13; j++) begin
            observe();
            if (m0_gnt || m1_gnt) begin
                if (ng < 3) begin
                    g_port[ng] = m1_gnt ? 1 : 0;
                    g_cyc[ng]  = j;
                end
                ng++;
            end
            apply_stimulus(s);
        end
        check_output("contention_grant0", g_port[0] * 256 + g_cyc[0], 0 * 256 + 1);
        check_output("contention_grant1", g_port[1] * 256 + g_cyc[1], 1 * 256 + 6);
        check_output("contention_grant2", g_port[2] * 256 + g_cyc[2], 0 * 256 + 11);
        idle_cycles(6);

        // Reset during the WAIT of the second beat of an 8-byte read.
        s = idle_stim();
        s.req0 = 1; s.addr0 = 16'h2000; s.len0 = 3'd7;
        for (int i = 0; i < 6; i++) begin
            observe();
            if (m0_gnt) s.req0 = 0;
            if (i == 5) s.rst = 0;
            apply_stimulus(s);
        end
        observe();
        check_output("rst_mid_busy", busy, 0);
        check_output("rst_mid_mstrb", sdram_mstrb, 0);
        apply_stimulus(idle_stim());
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            observe();
            ndone += int'(m0_done) + int'(m1_done);
            apply_stimulus(idle_stim());
        end
        check_output("rst_mid_no_done", ndone, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            observe();
            s.rst   = ($urandom_range(0, 199) != 0);
            s.req0  = ($urandom_range(0, 2) != 0);
            s.req1  = ($urandom_range(0, 2) != 0);
            s.addr0 = ($urandom_range(0, 3) == 0) ? (16'hFFF8 | 16'($urandom_range(0, 7))) : 16'($urandom);
            s.addr1 = 16'($urandom);
            s.len0  = 3'($urandom);
            s.len1  = 3'($urandom);
            s.wr0   = 1'($urandom);
            s.wr1   = 1'($urandom);
            s.wd0   = 8'($urandom);
            s.wd1   = 8'($urandom);
            apply_stimulus(s);
        end
        idle_cycles(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
